// File: rtl/sha1_sched_pkg.sv
// Shared constants, types and helpers for the SHA-1 round scheduler.
package sha1_sched_pkg;

    localparam int ROUND_NUM       = 80;
    localparam int ROUNDS_PER_FUNC = 20;

    // Round constants, one per 20-round function group.
    localparam logic [31:0] K_F0 = 32'h5A827999;
    localparam logic [31:0] K_F1 = 32'h6ED9EBA1;
    localparam logic [31:0] K_F2 = 32'h8F1BBCDC;
    localparam logic [31:0] K_F3 = 32'hCA62C1D6;

    typedef enum logic [1:0] {
        F_CH      = 2'd0,
        F_PARITY1 = 2'd1,
        F_MAJ     = 2'd2,
        F_PARITY2 = 2'd3
    } func_sel_t;

    typedef logic [6:0] round_t;

    localparam round_t LAST_ROUND = round_t'(ROUND_NUM - 1);

    // Function group of a round, found with three compares instead of a divide.
    function automatic func_sel_t func_of_round(input round_t r);
        func_sel_t f;
        if (r < round_t'(ROUNDS_PER_FUNC))
            f = F_CH;
        else if (r < round_t'(2 * ROUNDS_PER_FUNC))
            f = F_PARITY1;
        else if (r < round_t'(3 * ROUNDS_PER_FUNC))
            f = F_MAJ;
        else
            f = F_PARITY2;
        return f;
    endfunction

    // Round constant for a function group, for use by the round datapath.
    function automatic logic [31:0] k_of_func(input func_sel_t f);
        logic [31:0] k;
        case (f)
            F_CH:      k = K_F0;
            F_PARITY1: k = K_F1;
            F_MAJ:     k = K_F2;
            default:   k = K_F3;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sha1_sched_ctx_bank.sv
// Per-channel context store: round counter and busy flag for every channel.
// One read/update port serves returning feedback, one set port serves starts.
module sha1_sched_ctx_bank
    import sha1_sched_pkg::*;
#(
    parameter int CHANNEL_NUM_TOTAL = 64,
    parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNEL_NUM_WIDTH-1:0] rd_channel,
    output round_t                       rd_round,
    output logic                         rd_busy,
    input  logic                         upd_en,
    input  round_t                       upd_round,
    input  logic                         upd_busy,
    input  logic                         set_en,
    input  logic [CHANNEL_NUM_WIDTH-1:0] set_channel,
    output logic [CHANNEL_NUM_TOTAL-1:0] busy_map
);

    round_t                       rnd [CHANNEL_NUM_TOTAL];
    logic [CHANNEL_NUM_TOTAL-1:0] busy;

    // Feedback update wins; a start only lands when no feedback is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < CHANNEL_NUM_TOTAL; i++)
                rnd[i] <= '0;
        end else if (upd_en) begin
            rnd[rd_channel]  <= upd_round;
            busy[rd_channel] <= upd_busy;
        end else if (set_en) begin
            rnd[set_channel]  <= '0;
            busy[set_channel] <= 1'b1;
        end
    end

    assign rd_round = rnd[rd_channel];
    assign rd_busy  = busy[rd_channel];
    assign busy_map = busy;

endmodule

// File: rtl/sha1_round_scheduler.sv
// Sequences 80 SHA-1 rounds for interleaved channels through the round
// datapath: admits starts, re-issues tokens on feedback, reports completion.
module sha1_round_scheduler
    import sha1_sched_pkg::*;
#(
    parameter int CHANNEL_NUM_TOTAL = 64,
    parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_valid,
    input  logic [CHANNEL_NUM_WIDTH-1:0] start_channel,
    output logic                         start_ready,
    input  logic                         fb_valid,
    input  logic [CHANNEL_NUM_WIDTH-1:0] fb_channel,
    output logic                         issue_valid,
    output logic [CHANNEL_NUM_WIDTH-1:0] issue_channel,
    output logic [6:0]                   issue_round,
    output logic [1:0]                   issue_func_sel,
    output logic                         issue_first,
    output logic                         done_valid,
    output logic [CHANNEL_NUM_WIDTH-1:0] done_channel,
    output logic [CHANNEL_NUM_TOTAL-1:0] busy_map,
    output logic                         err_fb_idle
);

    round_t fb_round;
    round_t next_round;
    round_t upd_round;
    logic   fb_busy;
    logic   fb_adv;
    logic   fb_last;
    logic   start_fire;

    sha1_sched_ctx_bank #(
        .CHANNEL_NUM_TOTAL (CHANNEL_NUM_TOTAL),
        .CHANNEL_NUM_WIDTH (CHANNEL_NUM_WIDTH)
    ) u_ctx_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_channel  (fb_channel),
        .rd_round    (fb_round),
        .rd_busy     (fb_busy),
        .upd_en      (fb_valid & fb_busy),
        .upd_round   (upd_round),
        .upd_busy    (~fb_last),
        .set_en      (start_fire),
        .set_channel (start_channel),
        .busy_map    (busy_map)
    );

    assign start_ready = ~fb_valid & ~busy_map[start_channel];
    assign start_fire  = start_valid & start_ready;
    assign fb_adv      = fb_valid & fb_busy & (fb_round != LAST_ROUND);
    assign fb_last     = fb_valid & fb_busy & (fb_round == LAST_ROUND);
    assign next_round  = fb_round + 7'd1;
    assign upd_round   = fb_last ? '0 : next_round;

    // Registered issue/done/error outputs; data fields hold between events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid    <= 1'b0;
            issue_channel  <= '0;
            issue_round    <= '0;
            issue_func_sel <= '0;
            issue_first    <= 1'b0;
            done_valid     <= 1'b0;
            done_channel   <= '0;
            err_fb_idle    <= 1'b0;
        end else begin
            issue_valid <= fb_adv | start_fire;
            done_valid  <= fb_last;
            if (fb_adv) begin
                issue_channel  <= fb_channel;
                issue_round    <= next_round;
                issue_func_sel <= func_of_round(next_round);
                issue_first    <= 1'b0;
            end else if (start_fire) begin
                issue_channel  <= start_channel;
                issue_round    <= '0;
                issue_func_sel <= F_CH;
                issue_first    <= 1'b1;
            end
            if (fb_last)
                done_channel <= fb_channel;
            if (fb_valid && !fb_busy)
                err_fb_idle <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sha1_round_scheduler.sv
// Self-checking bench for sha1_round_scheduler with a per-channel reference model.
module tb_sha1_round_scheduler;

    localparam int CH = 64;
    localparam int W  = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_valid = 1'b0;
    logic [W-1:0]  start_channel = '0;
    logic          start_ready;
    logic          fb_valid = 1'b0;
    logic [W-1:0]  fb_channel = '0;
    logic          issue_valid;
    logic [W-1:0]  issue_channel;
    logic [6:0]    issue_round;
    logic [1:0]    issue_func_sel;
    logic          issue_first;
    logic          done_valid;
    logic [W-1:0]  done_channel;
    logic [CH-1:0] busy_map;
    logic          err_fb_idle;

    sha1_round_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_valid    (start_valid),
        .start_channel  (start_channel),
        .start_ready    (start_ready),
        .fb_valid       (fb_valid),
        .fb_channel     (fb_channel),
        .issue_valid    (issue_valid),
        .issue_channel  (issue_channel),
        .issue_round    (issue_round),
        .issue_func_sel (issue_func_sel),
        .issue_first    (issue_first),
        .done_valid     (done_valid),
        .done_channel   (done_channel),
        .busy_map       (busy_map),
        .err_fb_idle    (err_fb_idle)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: which channels are running and which round each last issued.
    bit m_busy [CH];
    int m_rnd  [CH];
    bit m_err;
    bit e_iv, e_first, e_dv, e_sr, a_sr;
    int e_ich, e_irnd, e_ifs, e_dch;

    typedef struct {
        int ch;
        int due;
    } fb_t;

    function automatic logic [16:0] exp_issue();
        return {e_iv, 6'(e_ich), 7'(e_irnd), 2'(e_ifs), e_first};
    endfunction

    function automatic logic [6:0] exp_done();
        return {e_dv, 6'(e_dch)};
    endfunction

    function automatic logic [CH-1:0] exp_busy();
        logic [CH-1:0] b;
        for (int i = 0; i < CH; i++)
            b[i] = m_busy[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_busy[i] = 0;
            m_rnd[i]  = 0;
        end
        m_err = 0;
        e_iv = 0; e_first = 0; e_dv = 0; e_sr = 0;
        e_ich = 0; e_irnd = 0; e_ifs = 0; e_dch = 0;
    endtask

    task automatic apply_reset();
        start_valid = 0;
        fb_valid    = 0;
        rst_n       = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    // Drive one cycle of inputs (called at posedge+1), predict the outcome, advance a cycle.
    task automatic cycle(input bit fv, input int fc, input bit sv, input int sc);
        fb_valid      = fv;
        fb_channel    = fc[W-1:0];
        start_valid   = sv;
        start_channel = sc[W-1:0];
        #1;
        a_sr = start_ready;
        e_sr = !fv && !m_busy[sc];
        e_iv = 0;
        e_dv = 0;
        if (fv) begin
            if (m_busy[fc]) begin
                if (m_rnd[fc] < 79) begin
                    m_rnd[fc] = m_rnd[fc] + 1;
                    e_iv = 1; e_ich = fc; e_irnd = m_rnd[fc];
                    e_ifs = m_rnd[fc] / 20; e_first = 0;
                end else begin
                    m_busy[fc] = 0; m_rnd[fc] = 0;
                    e_dv = 1; e_dch = fc;
                end
            end else begin
                m_err = 1;
            end
        end else if (sv && !m_busy[sc]) begin
            m_busy[sc] = 1; m_rnd[sc] = 0;
            e_iv = 1; e_ich = sc; e_irnd = 0; e_ifs = 0; e_first = 1;
        end
        @(posedge clk);
        #1;
        fb_valid    = 0;
        start_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        #3;
        checks++;
        if ({issue_valid, issue_channel, issue_round, issue_func_sel, issue_first} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_issue got=%h want=0", {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first});
        end
        checks++;
        if ({done_valid, done_channel} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_done got=%h want=0", {done_valid, done_channel});
        end
        checks++;
        if (busy_map !== '0) begin
            errors++;
            $display("[TB] FAIL reset_busy got=%h want=0", busy_map);
        end
        checks++;
        if (err_fb_idle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_err got=%b want=0", err_fb_idle);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_start_ready got=%b want=1", start_ready);
        end
    endtask

    task automatic test_single_channel();
        apply_reset();
        cycle(0, 0, 1, 5);
        checks++;
        if (a_sr !== e_sr) begin
            errors++;
            $display("[TB] FAIL single_start_ready got=%b want=%b", a_sr, e_sr);
        end
        checks++;
        if ({issue_valid, issue_channel, issue_round, issue_func_sel, issue_first} !== exp_issue()) begin
            errors++;
            $display("[TB] FAIL single_first_issue got=%h want=%h", {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first}, exp_issue());
        end
        checks++;
        if (busy_map !== exp_busy()) begin
            errors++;
            $display("[TB] FAIL single_busy got=%h want=%h", busy_map, exp_busy());
        end
        for (int r = 1; r <= 80; r++) begin
            cycle(0, 0, 0, 0);
            cycle(0, 0, 0, 0);
            checks++;
            if ({issue_valid, issue_channel, issue_round, issue_func_sel, issue_first} !== exp_issue()) begin
                errors++;
                $display("[TB] FAIL single_idle_hold r=%0d got=%h want=%h", r, {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first}, exp_issue());
            end
            cycle(1, 5, 0, 0);
            checks++;
            if ({issue_valid, issue_channel, issue_round, issue_func_sel, issue_first} !== exp_issue()) begin
                errors++;
                $display("[TB] FAIL single_issue r=%0d got=%h want=%h", r, {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first}, exp_issue());
            end
            checks++;
            if ({done_valid, done_channel} !== exp_done()) begin
                errors++;
                $display("[TB] FAIL single_done r=%0d got=%h want=%h", r, {done_valid, done_channel}, exp_done());
            end
        end
        checks++;
        if (busy_map !== exp_busy()) begin
            errors++;
            $display("[TB] FAIL single_busy_end got=%h want=%h", busy_map, exp_busy());
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (done_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_done_pulse got=%b want=0", done_valid);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        cycle(0, 0, 1, 3);
        cycle(1, 3, 1, 7);
        checks++;
        if (a_sr !== e_sr) begin
            errors++;
            $display("[TB] FAIL prio_start_ready got=%b want=%b", a_sr, e_sr);
        end
        checks++;
        if ({issue_valid, issue_channel, issue_round, issue_func_sel, issue_first} !== exp_issue()) begin
            errors++;
            $display("[TB] FAIL prio_fb_issue got=%h want=%h", {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first}, exp_issue());
        end
        cycle(0, 0, 1, 7);
        checks++;
        if (a_sr !== e_sr) begin
            errors++;
            $display("[TB] FAIL prio_retry_ready got=%b want=%b", a_sr, e_sr);
        end
        checks++;
        if ({issue_valid, issue_channel, issue_round, issue_func_sel, issue_first} !== exp_issue()) begin
            errors++;
            $display("[TB] FAIL prio_start_issue got=%h want=%h", {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first}, exp_issue());
        end
    endtask

    task automatic test_busy_start();
        int other;
        apply_reset();
        other = $urandom_range(CH - 1, 10);
        cycle(0, 0, 1, 9);
        for (int r = 1; r <= 80; r++) begin
            cycle(0, 0, 1, (r == 40) ? other : 9);
            checks++;
            if (a_sr !== e_sr || {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first} !== exp_issue()) begin
                errors++;
                $display("[TB] FAIL busy_start r=%0d ready=%b/%b issue=%h/%h", r, a_sr, e_sr, {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first}, exp_issue());
            end
            cycle(1, 9, 0, 0);
            checks++;
            if ({done_valid, done_channel} !== exp_done() || busy_map !== exp_busy()) begin
                errors++;
                $display("[TB] FAIL busy_fb r=%0d done=%h/%h busy=%h/%h", r, {done_valid, done_channel}, exp_done(), busy_map, exp_busy());
            end
        end
        cycle(0, 0, 1, 9);
        checks++;
        if (a_sr !== 1'b1 || {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first} !== exp_issue()) begin
            errors++;
            $display("[TB] FAIL busy_restart ready=%b want=1 issue=%h/%h", a_sr, {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first}, exp_issue());
        end
    endtask

    task automatic test_idle_fb();
        int c;
        apply_reset();
        c = $urandom_range(CH - 1, 0);
        cycle(1, c, 0, 0);
        checks++;
        if (issue_valid !== 1'b0 || done_valid !== 1'b0 || busy_map !== '0) begin
            errors++;
            $display("[TB] FAIL idle_fb_effect ch=%0d issue=%b done=%b busy=%h want 0/0/0", c, issue_valid, done_valid, busy_map);
        end
        checks++;
        if (err_fb_idle !== m_err) begin
            errors++;
            $display("[TB] FAIL idle_fb_err got=%b want=%b", err_fb_idle, m_err);
        end
        cycle(0, 0, 1, c);
        cycle(1, c, 0, 0);
        cycle(0, 0, 0, 0);
        checks++;
        if (err_fb_idle !== 1'b1 || issue_round !== 7'd1) begin
            errors++;
            $display("[TB] FAIL idle_fb_sticky err=%b want=1 round=%0d want=1", err_fb_idle, issue_round);
        end
        apply_reset();
        checks++;
        if (err_fb_idle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_fb_clear got=%b want=0", err_fb_idle);
        end
    endtask

    task automatic test_back_to_back();
        fb_t q[$];
        fb_t item;
        int  perm [CH];
        int  done_cnt [CH];
        int  idx, now, j, tmp, fc, sc;
        bit  fv, sv;
        apply_reset();
        for (int i = 0; i < CH; i++) begin
            perm[i] = i;
            done_cnt[i] = 0;
        end
        for (int i = CH - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        idx = 0;
        now = 0;
        while ((idx < CH || q.size() > 0) && now < 12000) begin
            fv = 0; fc = 0; sv = 0; sc = 0;
            if (q.size() > 0 && q[0].due <= now) begin
                fv = 1;
                fc = q[0].ch;
                void'(q.pop_front());
            end
            if (idx < CH) begin
                sv = 1;
                sc = perm[idx];
            end
            cycle(fv, fc, sv, sc);
            if (sv && e_sr)
                idx++;
            checks++;
            if (a_sr !== e_sr || {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first} !== exp_issue()
                || {done_valid, done_channel} !== exp_done()) begin
                errors++;
                $display("[TB] FAIL b2b t=%0d ready=%b/%b issue=%h/%h done=%h/%h", now, a_sr, e_sr,
                         {issue_valid, issue_channel, issue_round, issue_func_sel, issue_first}, exp_issue(),
                         {done_valid, done_channel}, exp_done());
            end
            if (e_iv) begin
                item.ch  = e_ich;
                item.due = now + 2;
                q.push_back(item);
            end
            if (done_valid === 1'b1)
                done_cnt[done_channel]++;
            now++;
        end
        checks++;
        if (now >= 12000) begin
            errors++;
            $display("[TB] FAIL b2b_timeout cycles=%0d limit=12000", now);
        end
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (done_cnt[i] != 1) begin
                errors++;
                $display("[TB] FAIL b2b_done_count ch=%0d got=%0d want=1", i, done_cnt[i]);
            end
        end
        checks++;
        if (busy_map !== '0) begin
            errors++;
            $display("[TB] FAIL b2b_busy_end got=%h want=0", busy_map);
        end
    endtask

    task automatic test_reset_mid_run();
        int c;
        apply_reset();
        c = $urandom_range(CH - 1, 0);
        cycle(0, 0, 1, c);
        cycle(0, 0, 1, (c + 1) % CH);
        cycle(1, c, 0, 0);
        #3;
        rst_n = 0;
        #1;
        checks++;
        if (busy_map !== '0 || issue_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_async busy=%h issue=%b want 0/0", busy_map, issue_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        cycle(1, c, 0, 0);
        checks++;
        if (issue_valid !== 1'b0 || err_fb_idle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_stale_fb issue=%b want=0 err=%b want=1", issue_valid, err_fb_idle);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_priority();
        test_busy_start();
        test_idle_fb();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha1_round_scheduler.md
Name: sha1_round_scheduler

Overview:
Sequences the 80 SHA-1 rounds for up to CHANNEL_NUM_TOTAL interleaved message blocks through the pipelined round datapath. Admits new block starts, re-issues each channel's token when its round result returns on the feedback path, and tags every issue with round index and function select (0..3). Reports completion per channel. Sits between the block-load front end and the four round-function stages.

Parameters:
CHANNEL_NUM_TOTAL, 64, number of independent channels/contexts
CHANNEL_NUM_WIDTH, $clog2(CHANNEL_NUM_TOTAL), channel id width
ROUND_NUM, 80, rounds per block
ROUNDS_PER_FUNC, 20, rounds per function group

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  request to begin a block on start_channel
start_channel  in  CHANNEL_NUM_WIDTH  channel of start request
start_ready  out  1  start accepted this cycle when high with start_valid
fb_valid  in  1  round result returned from datapath (data_new_valid)
fb_channel  in  CHANNEL_NUM_WIDTH  channel of returned result (channel_num_new)
issue_valid  out  1  token issued to datapath
issue_channel  out  CHANNEL_NUM_WIDTH  channel of issued token
issue_round  out  7  round index 0..79
issue_func_sel  out  2  issue_round/20
issue_first  out  1  high for round 0: datapath muxes initial H state, not feedback
done_valid  out  1  one-cycle pulse: channel finished round 79
done_channel  out  CHANNEL_NUM_WIDTH  finished channel
busy_map  out  CHANNEL_NUM_TOTAL  bit c set while channel c in flight
err_fb_idle  out  1  sticky: feedback received for non-busy channel

Behaviour:
- Reset (async assert, sync release): all outputs 0, busy_map 0, all round counters 0, err_fb_idle 0. Reset mid-operation drops all in-flight contexts; returning feedback after release is flagged as err_fb_idle.
- Per-channel state: rnd[c] 7-bit, busy[c].
- start_ready = ~fb_valid & ~busy[start_channel] (combinational; depends on start_channel).
- Accepted start (c): next cycle issue_valid=1, issue_channel=c, issue_round=0, issue_func_sel=0, issue_first=1; busy[c]<=1, rnd[c]<=0.
- Feedback has strict priority over starts; at most one issue per cycle.
- fb_valid, busy[c]=1, rnd[c]<79: rnd[c]<=rnd[c]+1; next cycle issue with round rnd[c]+1, issue_first=0.
- fb_valid, busy[c]=1, rnd[c]=79: no issue; next cycle done_valid=1, done_channel=c; busy[c]<=0, rnd[c]<=0. Channel startable the following cycle.
- fb_valid, busy[c]=0: ignored (no issue, no state change), err_fb_idle<=1 until reset.
- func_sel: 0 for 0..19, 1 for 20..39, 2 for 40..59, 3 for 60..79; derived by compare, no divider.
- Latency: accept/feedback to issue = 1 cycle; last feedback to done = 1 cycle.
- Idle cycles: issue_valid=0, done_valid=0; issue_* data fields hold last value.
- Start on busy channel: start_ready=0, requester holds; no state change.

Decomposition:
- Package sha1_sched_pkg: ROUND_NUM, ROUNDS_PER_FUNC, K constants (5A827999, 6ED9EBA1, 8F1BBCDC, CA62C1D6), typedef func_sel_t (2-bit enum F_CH, F_PARITY1, F_MAJ, F_PARITY2), round_t (7-bit).
- One sub-module: sha1_sched_ctx_bank (per-channel rnd/busy array, one read/update port for feedback, one set port for start).

Test Plan:
- Reset, start_valid=1 ch=5 -> start_ready=1; next cycle issue_valid=1, channel 5, round 0, func 0, first=1; busy_map[5]=1.
- Loop issue back as feedback with 2-cycle delay for ch 5 -> rounds 0..79 issued, func_sel changes at 20/40/60; 80th feedback -> done_valid pulse ch 5, busy_map=0.
- fb_valid and start_valid same cycle (ch 3 fb, ch 7 start) -> start_ready=0, issue is ch 3; start accepted next free cycle.
- Start ch 9 while busy -> start_ready=0 until cycle after done for ch 9; other channels unaffected.
- fb_valid for idle ch 12 -> no issue, err_fb_idle=1 sticky; cleared only by rst_n.
- 64 channels started back-to-back with 2-cycle feedback loop -> all 64 done pulses, each exactly once, no dropped or duplicated issues; rst_n mid-run -> busy_map=0 immediately.
